// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sa_state_e;

  localparam int SA_DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder_bit.sv
// One-bit full-adder cell, purely combinational.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic car
);

  assign s   = a ^ b ^ c;
  assign car = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: latches operands on start, adds one bit pair per clock
// LSB first through a single full-adder cell, then pulses done with sum/cout.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);

  sa_state_e          r_state;
  sa_state_e          w_next;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_cout;
  logic               w_s;
  logic               w_car;
  logic               w_load;
  logic               w_last;

  full_adder_bit u_fa (
    .a   (r_a_sh[0]),
    .b   (r_b_sh[0]),
    .c   (r_carry),
    .s   (w_s),
    .car (w_car)
  );

  // A new addition may be accepted from IDLE or directly out of DONE (back-to-back).
  assign w_load = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_last = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next = ST_DONE;
      ST_DONE:  w_next = start ? ST_SHIFT : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Datapath: load on accept, one serial bit per SHIFT edge; sum fills from the MSB end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_load) begin
      r_a_sh  <= a_in;
      r_b_sh  <= b_in;
      r_carry <= cin;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_car;
      r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_cout <= w_car;
      end
    end
  end

  assign busy = (r_state == ST_SHIFT);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
